// File: rtl/fp_sub_pipe_if.sv
// Operand and result bus for fp_sub_pipe.
// master: the producer/consumer around the block; slave: fp_sub_pipe itself.
// AW = INT1+FRAC1, BW = INT2+FRAC2, DW = OUT_INT+OUT_FRAC.
interface fp_sub_pipe_if #(
   parameter int AW = 9,
   parameter int BW = 8,
   parameter int DW = 9
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] a;
   logic [BW-1:0] b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] diff;
   logic          overflow;
   logic [7:0]    ovf_count;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, overflow, ovf_count
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, overflow, ovf_count
   );
endinterface

// File: rtl/fp_sub_pipe.sv
// Three-stage fixed-point subtractor: diff = a - b.
//   S1 aligns both operands to a common IMAX.FMAX format,
//   S2 subtracts at full width (one guard bit, lossless),
//   S3 truncates to OUT_INT.OUT_FRAC and flags/handles overflow.
// A stalled output (out_valid && !out_ready) freezes the whole pipe.
// Build option: define FP_SUB_SAT_EN to saturate diff on overflow;
// otherwise diff wraps to its low OUT_INT+OUT_FRAC bits.
module fp_sub_pipe #(
   parameter int INT1     = 4,
   parameter int FRAC1    = 5,
   parameter int INT2     = 3,
   parameter int FRAC2    = 5,
   parameter int OUT_INT  = 4,
   parameter int OUT_FRAC = 5
) (
   input logic          clk,
   input logic          rst,
   fp_sub_pipe_if.slave bus
);

   localparam int AW   = INT1 + FRAC1;
   localparam int BW   = INT2 + FRAC2;
   localparam int IMAX = (INT1 > INT2) ? INT1 : INT2;
   localparam int FMAX = (FRAC1 > FRAC2) ? FRAC1 : FRAC2;
   localparam int W1   = IMAX + FMAX;
   localparam int WF   = W1 + 1;
   localparam int OW   = OUT_INT + OUT_FRAC;
   localparam int SH_A = FMAX - FRAC1;
   localparam int SH_B = FMAX - FRAC2;
   localparam int DROP = FMAX - OUT_FRAC;

   logic                 stall;
   logic                 s1_valid, s2_valid, s3_valid;
   logic signed [AW-1:0] a_s;
   logic signed [BW-1:0] b_s;
   logic signed [W1-1:0] a_al, b_al;
   logic signed [W1-1:0] s1_a, s1_b;
   logic signed [WF-1:0] s2_d;
   logic signed [WF-1:0] trunc;
   logic [WF-OW:0]       upper;
   logic                 ovf_nxt;
   logic [OW-1:0]        diff_nxt;
   logic [OW-1:0]        s3_diff;
   logic                 s3_ovf;
   logic [7:0]           ovf_cnt;

   // Reset forces in_ready high so operands offered during reset are simply dropped.
   assign stall        = rst && s3_valid && !bus.out_ready;
   assign bus.in_ready = !stall;

   // Sign-extend to IMAX integer bits, then zero-pad the fraction to FMAX bits.
   assign a_s  = signed'(bus.a);
   assign b_s  = signed'(bus.b);
   assign a_al = W1'(a_s) <<< SH_A;
   assign b_al = W1'(b_s) <<< SH_B;

   // Stage valid bits advance together unless the output is stalled.
   // NOTE: rst is sampled only at the clock edge (synchronous); no rst in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (!stall) begin
         s1_valid <= bus.in_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
      end
   end

   // S1/S2 data registers: align, then full-width subtract.
   // NOTE: these have no reset; the valid bits alone decide whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (!stall) begin
         s1_a <= a_al;
         s1_b <= b_al;
         s2_d <= WF'(s1_a) - WF'(s1_b);
      end
   end

   // S3 format: truncate toward minus infinity, detect range overflow, pick wrap or saturate.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      trunc    = s2_d >>> DROP;
      upper    = trunc[WF-1:OW-1];
      ovf_nxt  = !((&upper) || !(|upper));
      diff_nxt = trunc[OW-1:0];
`ifdef FP_SUB_SAT_EN
      if (ovf_nxt) begin
         diff_nxt         = {OW{~trunc[WF-1]}};
         diff_nxt[OW-1]   = trunc[WF-1];
      end
`endif
   end

   // S3 output register: diff and overflow stay aligned with out_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s3_diff <= '0;
         s3_ovf  <= 1'b0;
      end else if (!stall) begin
         s3_diff <= diff_nxt;
         s3_ovf  <= ovf_nxt;
      end
   end

   // Count results delivered with overflow set, holding at 255.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_cnt <= 8'd0;
      end else if (s3_valid && bus.out_ready && s3_ovf && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.diff      = s3_diff;
   assign bus.overflow  = s3_ovf;
   assign bus.ovf_count = ovf_cnt;

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Scoreboard bench for fp_sub_pipe at default parameters.
// An input monitor models every accepted operand pair with integer arithmetic
// and queues the expected result; an output monitor pops and compares on each
// output handshake. Directed cases cover the worked examples, stall, reset and
// counter saturation; a random phase exercises the rest.
module tb_fp_sub_pipe;

   localparam int INT1 = 4, FRAC1 = 5, INT2 = 3, FRAC2 = 5, OUT_INT = 4, OUT_FRAC = 5;
   localparam int AW   = INT1 + FRAC1;
   localparam int BW   = INT2 + FRAC2;
   localparam int OW   = OUT_INT + OUT_FRAC;
   localparam int FMAX = (FRAC1 > FRAC2) ? FRAC1 : FRAC2;

   typedef struct {
      logic [OW-1:0] d;
      logic          o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   int   n_out = 0;
   exp_t exp_q[$];

   fp_sub_pipe_if #(.AW(AW), .BW(BW), .DW(OW)) bus ();

   fp_sub_pipe #(
      .INT1(INT1), .FRAC1(FRAC1), .INT2(INT2), .FRAC2(FRAC2),
      .OUT_INT(OUT_INT), .OUT_FRAC(OUT_FRAC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   // Reference: exact difference in units of 2^-FMAX, floored to 2^-OUT_FRAC, range-checked.
   function automatic exp_t model(input logic [AW-1:0] av, input logic [BW-1:0] bv);
      exp_t   e;
      longint x, y, full, t, lo, hi;
      logic [63:0] t64;
      x    = longint'($signed(av)) * (longint'(1) << (FMAX - FRAC1));
      y    = longint'($signed(bv)) * (longint'(1) << (FMAX - FRAC2));
      full = x - y;
      t    = floor_div(full, longint'(1) << (FMAX - OUT_FRAC));
      hi   = (longint'(1) << (OW - 1)) - 1;
      lo   = -(longint'(1) << (OW - 1));
      e.o  = (t > hi) || (t < lo);
`ifdef FP_SUB_SAT_EN
      if (t > hi) t = hi;
      if (t < lo) t = lo;
`endif
      t64 = 64'(t);
      e.d = t64[OW-1:0];
      return e;
   endfunction

   // Input monitor: queue the expected result for every accepted operand pair.
   always @(negedge clk) begin
      if (rst && bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b));
   end

   // Output monitor: in_ready rule, then compare each delivered result in order.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
         if (bus.out_valid && bus.out_ready) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("diff", 32'(bus.diff), 32'(e.d));
               check("overflow", 32'(bus.overflow), 32'(e.o));
               check("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
               if (e.o && exp_cnt < 255) exp_cnt++;
            end
            n_out++;
         end
      end
   end

   task automatic drain();
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (exp_q.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      rst          = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = AW'($urandom);
      bus.b        = BW'($urandom);
      #1;
      check("in_ready_in_reset", 32'(bus.in_ready), 32'd1);
      repeat (cycles) @(posedge clk);
      #1;
      exp_q.delete();
      exp_cnt = 0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   // One operand pair into an empty pipe; returns accept-to-out_valid edge count.
   task automatic send_one(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                           output int lat, output logic [OW-1:0] d, output logic o);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = av;
      bus.b         = bv;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      d = bus.diff;
      o = bus.overflow;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat, base, sent, stall_seen;
      logic [OW-1:0] d;
      logic          o, acc;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      @(posedge clk); #1;
      do_reset(3);

      // 3.5 - 1.25 = 2.25
      send_one(9'h070, 8'h28, lat, d, o);
      check("ex1_latency", 32'(lat), 32'd3);
      check("ex1_diff", 32'(d), 32'h048);
      check("ex1_ovf", 32'(o), 32'd0);

      // 7.96875 - (-4.0) overflows high
      send_one(9'h0FF, 8'h80, lat, d, o);
      check("ex2_ovf", 32'(o), 32'd1);
`ifdef FP_SUB_SAT_EN
      check("ex2_diff", 32'(d), 32'h0FF);
`else
      check("ex2_diff", 32'(d), 32'h17F);
`endif
      check("ex2_count", 32'(bus.ovf_count), 32'd1);

      // -8.0 - 3.0 overflows low
      send_one(9'h100, 8'h60, lat, d, o);
      check("ex3_ovf", 32'(o), 32'd1);
`ifdef FP_SUB_SAT_EN
      check("ex3_diff", 32'(d), 32'h100);
`else
      check("ex3_diff", 32'(d), 32'h0A0);
`endif
      check("ex3_count", 32'(bus.ovf_count), 32'd2);

      // Five back-to-back inputs with out_ready low for four cycles mid-stream.
      base = n_out;
      sent = 0;
      stall_seen = 0;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid  = (sent < 5);
         bus.a         = AW'($urandom);
         bus.b         = BW'($urandom);
         bus.out_ready = !(c >= 4 && c < 8);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (!bus.in_ready) stall_seen++;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      drain();
      check("b2b_stall_cycles", 32'(stall_seen), 32'd4);
      check("b2b_sent", 32'(sent), 32'd5);
      check("b2b_outputs", 32'(n_out - base), 32'd5);

      // Reset with one result stalled at the output and two more in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 9'h0FF;
         bus.b        = 8'h80;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      do_reset(1);
      base = n_out;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("no_stale_out", 32'(n_out - base), 32'd0);
      check("no_stale_count", 32'(bus.ovf_count), 32'd0);

      // Random traffic with random back-pressure.
      for (int c = 0; c < 600; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.a         = AW'($urandom);
         bus.b         = BW'($urandom);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk); #1;
      end
      drain();

      // Counter saturation.
      do_reset(1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 9'h0FF;
         bus.b        = 8'h80;
         @(posedge clk); #1;
      end
      drain();
      check("ovf_count_sat", 32'(bus.ovf_count), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_sub_pipe.md
FP_SUB_PIPE -- requirements
Module: fp_sub_pipe

Interface
REQ-001 SHALL have parameter INT1, default 4: integer bits of a, sign included.
REQ-002 SHALL have parameter FRAC1, default 5: fraction bits of a.
REQ-003 SHALL have parameter INT2, default 3: integer bits of b, sign included.
REQ-004 SHALL have parameter FRAC2, default 5: fraction bits of b.
REQ-005 SHALL have parameter OUT_INT, default 4: integer bits of diff; legal range 1..max(INT1,INT2)+1.
REQ-006 SHALL have parameter OUT_FRAC, default 5: fraction bits of diff; legal range 0..max(FRAC1,FRAC2).
REQ-007 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 in_valid  input  1  a and b valid this cycle.
REQ-010 in_ready  output  1  block accepts the operands this cycle.
REQ-011 a  input  INT1+FRAC1  signed two's-complement minuend.
REQ-012 b  input  INT2+FRAC2  signed two's-complement subtrahend.
REQ-013 out_valid  output  1  diff and overflow valid.
REQ-014 out_ready  input  1  consumer accepts diff this cycle.
REQ-015 diff  output  OUT_INT+OUT_FRAC  signed result a-b.
REQ-016 overflow  output  1  result exceeded the diff range; aligned with diff.
REQ-017 ovf_count  output  8  saturating count of results delivered with overflow=1.

Function
REQ-018 Pipeline SHALL have 3 registered stages, each with a valid bit: S1 align, S2 subtract, S3 format/saturate.
REQ-019 S1 SHALL sign-extend a and b to IMAX=max(INT1,INT2) integer bits and zero-pad on the right to FMAX=max(FRAC1,FRAC2) fraction bits.
REQ-020 S2 SHALL compute a-b at full width IMAX+FMAX+1 bits, with no loss.
REQ-021 S3 SHALL drop the low FMAX-OUT_FRAC fraction bits (truncation toward minus infinity, no rounding).
REQ-022 S3 SHALL set overflow when the truncated value is outside [-2^(OUT_INT-1), 2^(OUT_INT-1)-2^-OUT_FRAC].
REQ-023 Transfer rules: input handshake = in_valid&&in_ready; output handshake = out_valid&&out_ready.
REQ-024 Stall = out_valid && !out_ready; while stalled, all stages and outputs SHALL hold.
REQ-025 in_ready SHALL equal !stall (combinational); no data is lost or duplicated.
REQ-026 Latency SHALL be 3 cycles from input handshake to out_valid when not stalled; throughput SHALL be 1 result per cycle.
REQ-027 ovf_count SHALL increment on each output handshake with overflow=1 and SHALL hold at 255.
REQ-028 Bubbles (in_valid=0) SHALL propagate as valid=0; diff and overflow are don't-care while out_valid=0.

Reset
REQ-029 While rst=0 at a clock edge, all stage valid bits, out_valid, overflow, diff and ovf_count SHALL be cleared to 0.
REQ-030 in_ready SHALL be 1 during reset; operands presented during reset SHALL be discarded.
REQ-031 Reset mid-operation SHALL discard all in-flight results; the first output after rst returns to 1 comes from a new input handshake.

Configuration
REQ-032 Macro FP_SUB_SAT_EN defined: on overflow, diff SHALL saturate to the positive maximum (01..1) or negative minimum (10..0), chosen by the full-width sign.
REQ-033 Macro FP_SUB_SAT_EN undefined: diff SHALL be the low OUT_INT+OUT_FRAC bits (wrap); overflow and ovf_count SHALL still be computed.

Verification (defaults)
REQ-034 a=0x070 (3.5), b=0x28 (1.25), out_ready=1 -> diff=0x048 (2.25), overflow=0, out_valid 3 cycles after accept.
REQ-035 a=0x0FF (7.96875), b=0x80 (-4.0) -> overflow=1; diff=0x0FF with FP_SUB_SAT_EN, 0x17F without; ovf_count=1.
REQ-036 a=0x100 (-8.0), b=0x60 (3.0) -> overflow=1; diff=0x100 with FP_SUB_SAT_EN, 0x0A0 without.
REQ-037 Back-to-back 5 inputs with out_ready low for 4 cycles mid-stream -> in_ready=0 while stalled; all 5 results in order with none lost or duplicated.
REQ-038 rst pulsed low with 2 results in flight -> out_valid=0 and ovf_count=0 next cycle; no stale result appears afterwards.
REQ-039 300 saturating overflow inputs -> ovf_count stops at 255.
